dist_sq: RTL and testbench

DIST_SQ -- requirements
Module: dist_sq

---
 rtl/dist_sq_pkg.sv | 14 +
 rtl/dist_sq_sq_step.sv | 16 +
 rtl/dist_sq.sv | 105 ++++++++++
 tb/tb_dist_sq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_sq_pkg.sv
// Shared types and widths for the distance-squared unit and the square-root stage wrapper.
package dist_sq_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dist_sq_sq_step.sv
// One shift-add iteration of an unsigned square: adds (mag << cnt) when bit cnt of mag is set.
module sq_step
    import dist_sq_pkg::*;
(
    input  logic [OPERAND_W-1:0] i_mag,
    input  logic [RESULT_W-1:0]  i_acc,
    input  logic [CNT_W-1:0]     i_cnt,
    output logic [RESULT_W-1:0]  o_acc_next
);

    logic [RESULT_W-1:0] w_partial;

    assign w_partial  = RESULT_W'(i_mag) << i_cnt;
    assign o_acc_next = i_mag[i_cnt] ? (i_acc + w_partial) : i_acc;

endmodule

// File: rtl/dist_sq.sv
// Computes dx*dx + dy*dy with two parallel 8-cycle shift-add squarers sharing one counter.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   MUL   | eight shift-add iterations in progress
//   DONE  | result held on out_data until consumed
module dist_sq #(
    parameter int OPERAND_W = dist_sq_pkg::OPERAND_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPERAND_W-1:0]          dx,
    input  logic [OPERAND_W-1:0]          dy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [dist_sq_pkg::RESULT_W-1:0] out_data
);

    import dist_sq_pkg::*;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [OPERAND_W-1:0]   r_mag_x;
    logic [OPERAND_W-1:0]   r_mag_y;
    logic [RESULT_W-1:0]    r_acc_x;
    logic [RESULT_W-1:0]    r_acc_y;
    logic [CNT_W-1:0]       r_cnt;
    logic [RESULT_W-1:0]    r_out_data;

    logic [OPERAND_W-1:0]   w_mag_x;
    logic [OPERAND_W-1:0]   w_mag_y;
    logic [RESULT_W-1:0]    w_acc_x_next;
    logic [RESULT_W-1:0]    w_acc_y_next;
    logic                   w_in_xfer;
    logic                   w_last_step;

    // -128 negates to 8'h80, which read as unsigned is the required magnitude 128
    assign w_mag_x = dx[OPERAND_W-1] ? (~dx + OPERAND_W'(1)) : dx;
    assign w_mag_y = dy[OPERAND_W-1] ? (~dy + OPERAND_W'(1)) : dy;

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_data    = r_out_data;
    assign w_in_xfer   = in_valid && in_ready;
    assign w_last_step = &r_cnt;

    sq_step u_sq_x (
        .i_mag      (r_mag_x),
        .i_acc      (r_acc_x),
        .i_cnt      (r_cnt),
        .o_acc_next (w_acc_x_next)
    );

    sq_step u_sq_y (
        .i_mag      (r_mag_y),
        .i_acc      (r_acc_y),
        .i_cnt      (r_cnt),
        .o_acc_next (w_acc_y_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_state_next = MUL;
            MUL:     if (w_last_step) w_state_next = DONE;
            DONE:    if (out_ready)   w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag_x    <= '0;
            r_mag_y    <= '0;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
        end else if (w_in_xfer) begin
            r_mag_x <= w_mag_x;
            r_mag_y <= w_mag_y;
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_cnt   <= '0;
        end else if (r_state == MUL) begin
            r_acc_x <= w_acc_x_next;
            r_acc_y <= w_acc_y_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            // the sum must include the eighth partial product, so take it from the step outputs
            if (w_last_step) begin
                r_out_data <= w_acc_x_next + w_acc_y_next;
            end
        end
    end

endmodule

// File: tb/tb_dist_sq.sv
// Self-checking bench for dist_sq: a queue of expected radicands is filled on input transfers and drained on results.
module tb_dist_sq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic [15:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    dist_sq #(.OPERAND_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dx        (dx),
        .dy        (dy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb_v;
        sa   = int'($signed(a));
        sb_v = int'($signed(b));
        return 16'(sa * sa + sb_v * sb_v);
    endfunction

    function automatic logic [15:0] isqrt32(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (64'(t) * 64'(t) <= 64'(v)) r = t;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, performs one input transfer, then scrambles the operand bus.
    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_wait_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        dx = a;
        dy = b;
        tick();
        in_valid = 1'b0;
        sb.push_back(model(a, b));
        dx = 8'($urandom);
        dy = 8'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dx = 8'h00;
        dy = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        n_tests++;
        if (out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h required 0000", out_data);
        end
    endtask

    task automatic test_basic();
        int          lat;
        logic [15:0] exp_v;
        out_ready = 1'b1;
        send_op(8'd3, 8'd4);
        wait_valid(lat);
        n_tests++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 8", lat);
        end
        exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        n_tests++;
        if (out_data !== exp_v || out_data !== 16'd25) begin
            n_fail++;
            $display("FAIL basic_data: got %h required %h", out_data, exp_v);
        end
        n_tests++;
        if (isqrt32({out_data, 16'h0000}) !== 16'h0500) begin
            n_fail++;
            $display("FAIL basic_sqrt: got %h required 0500", isqrt32({out_data, 16'h0000}));
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: in_ready=%b required 0 in DONE", in_ready);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== exp_v) begin
            n_fail++;
            $display("FAIL basic_idle: in_ready=%b out_valid=%b out_data=%h required 1 0 %h",
                     in_ready, out_valid, out_data, exp_v);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  cx[3];
        logic [7:0]  cy[3];
        logic [15:0] cexp[3];
        int          lat;
        logic [15:0] exp_v;
        cx = '{8'h80, 8'h7F, 8'h00};
        cy = '{8'h80, 8'hFF, 8'h00};
        cexp = '{16'h8000, 16'd16130, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_op(cx[i], cy[i]);
            wait_valid(lat);
            n_tests++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL corner%0d_latency: got %0d required 8", i, lat);
            end
            exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_tests++;
            if (out_data !== exp_v || out_data !== cexp[i]) begin
                n_fail++;
                $display("FAIL corner%0d_data: got %h required %h", i, out_data, cexp[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [15:0] exp_v;
        int          seen;
        out_ready = 1'b0;
        send_op(8'd3, 8'd4);
        wait_valid(lat);
        n_tests++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d required 8", lat);
        end
        exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        in_valid = 1'b1;
        dx = 8'd9;
        dy = 8'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid=%b out_data=%h in_ready=%b required 1 %h 0",
                         i, out_valid, out_data, in_ready, exp_v);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL bp_no_extra: got %0d stray results required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        send_op(8'd50, 8'd60);
        void'(sb.pop_back());
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_state: out_valid=%b in_ready=%b out_data=%h required 0 1 0000",
                     out_valid, in_ready, out_data);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_result: got %0d results required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ox[2];
        logic [7:0]  oy[2];
        logic [15:0] rexp[2];
        int          acc_cyc[$];
        int          got;
        int          idx;
        logic        accept_now;
        logic [15:0] exp_v;
        ox = '{8'd1, 8'hFB};
        oy = '{8'd1, 8'd12};
        rexp = '{16'd2, 16'd169};
        got = 0;
        idx = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        dx = ox[0];
        dy = oy[0];
        for (int k = 0; k < 40 && got < 2; k++) begin
            if (out_valid === 1'b1) begin
                exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
                n_tests++;
                if (out_data !== exp_v || out_data !== rexp[got]) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h required %h", got, out_data, rexp[got]);
                end
                got++;
            end
            accept_now = (in_ready === 1'b1) && in_valid;
            if (accept_now) begin
                sb.push_back(model(dx, dy));
                acc_cyc.push_back(cyc);
            end
            tick();
            if (accept_now) begin
                idx++;
                if (idx < 2) begin
                    dx = ox[idx];
                    dy = oy[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required 2", got);
        end
        n_tests++;
        if (acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d accepts, gap %0d required 2 accepts gap 10",
                     acc_cyc.size(), (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
